// File: rtl/regbank_pkg.sv
// Shared width helpers for the register-bank write arbiter and readers of the bank.
package regbank_pkg;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
    import regbank_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = idx_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic            en,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx,
    output logic            gnt_valid
);

    // Walk N slots starting at ptr, wrapping modulo N.
    always_comb begin
        int unsigned idx;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr) + off) % N;
            if (en && !gnt_valid && req[IdxW'(idx)]) begin
                gnt[IdxW'(idx)] = 1'b1;
                gnt_idx         = IdxW'(idx);
                gnt_valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin write arbiter feeding a one-entry stage that commits into a
// Depth x Width register bank; read port forwards the staged write.
module regbank_wr_arbiter
    import regbank_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned Width  = 8,
    parameter int unsigned Depth  = 8,
    parameter int unsigned AddrW  = idx_w(Depth)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [Depth*Width-1:0]    RST_VAL,
    input  logic                      HOLD,
    input  logic [NumReq-1:0]         REQ_VALID,
    output logic [NumReq-1:0]         REQ_READY,
    input  logic [NumReq*AddrW-1:0]   REQ_ADDR,
    input  logic [NumReq*Width-1:0]   REQ_DATA,
    input  logic [AddrW-1:0]          RD_ADDR,
    output logic [Width-1:0]          RD_DATA,
    output logic                      WR_COMMIT,
    output logic [AddrW-1:0]          WR_ADDR,
    output logic [idx_w(NumReq)-1:0]  WR_SRC
);

    localparam int unsigned SrcW = idx_w(NumReq);

    logic [Width-1:0] bank_q [Depth];
    logic [SrcW-1:0]  ptr_q,      ptr_d;
    logic             stg_vld_q,  stg_vld_d;
    logic [AddrW-1:0] stg_addr_q, stg_addr_d;
    logic [Width-1:0] stg_data_q, stg_data_d;
    logic [SrcW-1:0]  stg_src_q,  stg_src_d;

    logic [NumReq-1:0] gnt;
    logic [SrcW-1:0]   gnt_idx;
    logic              gnt_valid;
    logic              commit_c;

    rr_arbiter #(
        .N    (NumReq),
        .IdxW (SrcW)
    ) u_arb (
        .req       (REQ_VALID),
        .en        (!HOLD && !RST),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign REQ_READY = gnt;

    // A staged write held across a reset edge is discarded, so it never reports a commit.
    assign commit_c  = stg_vld_q && !RST;
    assign WR_COMMIT = commit_c;
    assign WR_ADDR   = stg_addr_q;
    assign WR_SRC    = stg_src_q;

    // Next pointer and stage contents from the current grant.
    always_comb begin
        ptr_d      = ptr_q;
        stg_vld_d  = 1'b0;
        stg_addr_d = stg_addr_q;
        stg_data_d = stg_data_q;
        stg_src_d  = stg_src_q;
        if (gnt_valid) begin
            ptr_d      = (32'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + SrcW'(1);
            stg_vld_d  = 1'b1;
            stg_addr_d = REQ_ADDR[32'(gnt_idx)*AddrW +: AddrW];
            stg_data_d = REQ_DATA[32'(gnt_idx)*Width +: Width];
            stg_src_d  = gnt_idx;
        end
    end

    // Pointer and stage registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q      <= '0;
            stg_vld_q  <= 1'b0;
            stg_addr_q <= '0;
            stg_data_q <= '0;
            stg_src_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            stg_vld_q  <= stg_vld_d;
            stg_addr_q <= stg_addr_d;
            stg_data_q <= stg_data_d;
            stg_src_q  <= stg_src_d;
        end
    end

    // Bank: load reset values, otherwise commit the staged write; out-of-range addresses match no entry.
    always_ff @(posedge CLK) begin
        for (int unsigned k = 0; k < Depth; k++) begin
            if (RST) begin
                bank_q[k] <= RST_VAL[k*Width +: Width];
            end else if (stg_vld_q && stg_addr_q == AddrW'(k)) begin
                bank_q[k] <= stg_data_q;
            end
        end
    end

    // Read port with forwarding from the committing stage.
    always_comb begin
        RD_DATA = '0;
        if (32'(RD_ADDR) < Depth) begin
            if (commit_c && stg_addr_q == RD_ADDR) begin
                RD_DATA = stg_data_q;
            end else begin
                RD_DATA = bank_q[RD_ADDR];
            end
        end
    end

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed table-driven bench for regbank_wr_arbiter (4 requesters, 8x8 bank).
module tb_regbank_wr_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [63:0] RST_VAL;
    logic        HOLD;
    logic [3:0]  REQ_VALID;
    logic [3:0]  REQ_READY;
    logic [11:0] REQ_ADDR;
    logic [31:0] REQ_DATA;
    logic [2:0]  RD_ADDR;
    logic [7:0]  RD_DATA;
    logic        WR_COMMIT;
    logic [2:0]  WR_ADDR;
    logic [1:0]  WR_SRC;

    int checks   = 0;
    int failures = 0;

    regbank_wr_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .RST_VAL   (RST_VAL),
        .HOLD      (HOLD),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_DATA  (REQ_DATA),
        .RD_ADDR   (RD_ADDR),
        .RD_DATA   (RD_DATA),
        .WR_COMMIT (WR_COMMIT),
        .WR_ADDR   (WR_ADDR),
        .WR_SRC    (WR_SRC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        hold;
        logic [3:0]  valid;
        logic [11:0] addr;
        logic [31:0] data;
        logic [2:0]  rd;
        logic [3:0]  e_ready;
        logic        e_commit;
        logic [2:0]  e_waddr;
        logic [1:0]  e_src;
        logic [7:0]  e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic hold, logic [3:0] valid,
                                logic [11:0] addr, logic [31:0] data, logic [2:0] rd,
                                logic [3:0] e_ready, logic e_commit, logic [2:0] e_waddr,
                                logic [1:0] e_src, logic [7:0] e_rd);
        vec_t v;
        v.rst = rst; v.hold = hold; v.valid = valid; v.addr = addr; v.data = data;
        v.rd = rd; v.e_ready = e_ready; v.e_commit = e_commit; v.e_waddr = e_waddr;
        v.e_src = e_src; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h exp=%0h", name, row, act, exp);
        end
    endtask

    localparam logic [11:0] FAIR_A = {3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [31:0] FAIR_D = 32'h43424140;

    initial begin
        bit got;
        for (int k = 0; k < 8; k++) RST_VAL[k*8 +: 8] = 8'(8'h10 + k);
        RST = 1'b1; HOLD = 1'b0; REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0; RD_ADDR = '0;

        // Reset held for this edge plus the first table row.
        vecs.push_back(mk(1, 0, 4'b1111, FAIR_A, FAIR_D, 3'd0, 4'b0000, 0, 3'd0, 2'd0, 8'h10));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 0, 4'b0000, 12'h0, 32'h0, 3'(k), 4'b0000, 0, 3'd0, 2'd0, 8'(8'h10 + k)));
        // Single write req1 addr3 = A5.
        vecs.push_back(mk(0, 0, 4'b0010, {3'd0, 3'd0, 3'd3, 3'd0}, 32'h0000A500, 3'd3, 4'b0010, 0, 3'd0, 2'd0, 8'h13));
        vecs.push_back(mk(0, 0, 4'b0000, 12'h0, 32'h0, 3'd3, 4'b0000, 1, 3'd3, 2'd1, 8'hA5));
        vecs.push_back(mk(0, 0, 4'b0000, 12'h0, 32'h0, 3'd3, 4'b0000, 0, 3'd3, 2'd1, 8'hA5));
        // Reset again, then fairness with all valid.
        vecs.push_back(mk(1, 0, 4'b0000, 12'h0, 32'h0, 3'd3, 4'b0000, 0, 3'd3, 2'd1, 8'hA5));
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0001, 0, 3'd0, 2'd0, 8'h17));
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0010, 1, 3'd0, 2'd0, 8'h17));
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0100, 1, 3'd1, 2'd1, 8'h17));
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b1000, 1, 3'd2, 2'd2, 8'h17));
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0001, 1, 3'd3, 2'd3, 8'h17));
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0010, 1, 3'd0, 2'd0, 8'h17));
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0100, 1, 3'd1, 2'd1, 8'h17));
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b1000, 1, 3'd2, 2'd2, 8'h17));
        // HOLD after the grant to req1; staged write still commits, next grant goes to req2.
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0001, 1, 3'd3, 2'd3, 8'h17));
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0010, 1, 3'd0, 2'd0, 8'h17));
        vecs.push_back(mk(0, 1, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0000, 1, 3'd1, 2'd1, 8'h17));
        vecs.push_back(mk(0, 1, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0000, 0, 3'd1, 2'd1, 8'h17));
        vecs.push_back(mk(0, 1, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0000, 0, 3'd1, 2'd1, 8'h17));
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd7, 4'b0100, 0, 3'd1, 2'd1, 8'h17));
        vecs.push_back(mk(0, 0, 4'b0000, FAIR_A, FAIR_D, 3'd7, 4'b0000, 1, 3'd2, 2'd2, 8'h17));
        // Same-address collision: req0 5=11 then req2 5=22.
        vecs.push_back(mk(0, 0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}, 32'h00000011, 3'd5, 4'b0001, 0, 3'd2, 2'd2, 8'h15));
        vecs.push_back(mk(0, 0, 4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, 32'h00220000, 3'd5, 4'b0100, 1, 3'd5, 2'd0, 8'h11));
        vecs.push_back(mk(0, 0, 4'b0000, 12'h0, 32'h0, 3'd5, 4'b0000, 1, 3'd5, 2'd2, 8'h22));
        vecs.push_back(mk(0, 0, 4'b0000, 12'h0, 32'h0, 3'd5, 4'b0000, 0, 3'd5, 2'd2, 8'h22));
        // Reset with a write staged: discarded, bank[2] back to reset value, pointer 0.
        vecs.push_back(mk(0, 0, 4'b0100, {3'd0, 3'd2, 3'd0, 3'd0}, 32'h00FF0000, 3'd2, 4'b0100, 0, 3'd5, 2'd2, 8'h42));
        vecs.push_back(mk(1, 0, 4'b0000, 12'h0, 32'h0, 3'd0, 4'b0000, 0, 3'd2, 2'd2, 8'h40));
        vecs.push_back(mk(0, 0, 4'b0000, 12'h0, 32'h0, 3'd2, 4'b0000, 0, 3'd0, 2'd0, 8'h12));
        vecs.push_back(mk(0, 0, 4'b1111, FAIR_A, FAIR_D, 3'd5, 4'b0001, 0, 3'd0, 2'd0, 8'h15));
        vecs.push_back(mk(0, 0, 4'b0000, 12'h0, 32'h0, 3'd5, 4'b0000, 1, 3'd0, 2'd0, 8'h15));

        @(posedge CLK);
        foreach (vecs[i]) begin
            #1;
            RST = vecs[i].rst; HOLD = vecs[i].hold; REQ_VALID = vecs[i].valid;
            REQ_ADDR = vecs[i].addr; REQ_DATA = vecs[i].data; RD_ADDR = vecs[i].rd;
            @(negedge CLK);
            check("ready",  i, 32'(REQ_READY), 32'(vecs[i].e_ready));
            check("commit", i, 32'(WR_COMMIT), 32'(vecs[i].e_commit));
            check("waddr",  i, 32'(WR_ADDR),   32'(vecs[i].e_waddr));
            check("src",    i, 32'(WR_SRC),    32'(vecs[i].e_src));
            check("rd",     i, 32'(RD_DATA),   32'(vecs[i].e_rd));
            @(posedge CLK);
        end

        // Request dropped while HOLD is high is lost; nothing commits.
        #1; HOLD = 1'b1; REQ_VALID = 4'b1000; REQ_ADDR = {3'd4, 9'd0}; REQ_DATA = 32'hEE000000; RD_ADDR = 3'd4;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            check("hold_ready", c, 32'(REQ_READY), 32'h0);
            @(posedge CLK); #1;
        end
        HOLD = 1'b0; REQ_VALID = 4'b0000;
        @(negedge CLK);
        check("drop_commit", 0, 32'(WR_COMMIT), 32'h0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("drop_rd", 0, 32'(RD_DATA), 32'h14);

        // Bounded wait for req1's grant, then its commit and forwarded read.
        @(posedge CLK); #1;
        REQ_VALID = 4'b0010; REQ_ADDR = {3'd0, 3'd0, 3'd6, 3'd0}; REQ_DATA = 32'h00006600; RD_ADDR = 3'd6;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge CLK);
            if (REQ_READY[1]) got = 1'b1;
            else begin @(posedge CLK); #1; end
        end
        check("wait_ready", 0, 32'(got), 32'h1);
        @(posedge CLK); #1;
        REQ_VALID = 4'b0000;
        @(negedge CLK);
        check("late_commit", 0, 32'(WR_COMMIT), 32'h1);
        check("late_src",    0, 32'(WR_SRC),    32'h1);
        check("late_waddr",  0, 32'(WR_ADDR),   32'h6);
        check("late_rd",     0, 32'(RD_DATA),   32'h66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
